// File: rtl/result_byte_packer.sv
// rtl/result_byte_packer.sv - captures 16-bit results on status rising edge, buffers, drains as MSB-first byte stream
//
// Ports:
//   clk, rst       single clock, synchronous active-high reset
//   result_in      16-bit result word sampled on a capture
//   status_in      capture strobe; a rising edge (while enable=1) marks a valid result
//   enable         capture enable
//   clear_stats    zeroes overflow and drop_count
//   byte_out/byte_valid/byte_ready/byte_last  8-bit output stream, last flags the LSB byte
//   fifo_level     words held in the FIFO (excludes the word in the output register)
//   overflow       sticky drop flag
//   drop_count     saturating count of dropped captures

module result_byte_packer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              result_in,
    input  logic                     status_in,
    input  logic                     enable,
    input  logic                     clear_stats,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     byte_last,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_status_d;
    logic [15:0]        r_mem [DEPTH];
    logic [LVL_W-1:0]   r_wr_ptr;
    logic [LVL_W-1:0]   r_rd_ptr;
    logic [7:0]         r_byte_out;
    logic [7:0]         r_lo_byte;
    logic               r_byte_valid;
    logic               r_byte_last;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_drop_count;

    logic               w_cap;
    logic [LVL_W-1:0]   w_level;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [15:0]        w_head;

    // Pointers carry one extra bit so full and empty differ at equal indices.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == LVL_W'(DEPTH));
    assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_cap   = status_in & ~r_status_d & enable;

    // The head moves to the output register from IDLE, or straight after the
    // LSB handshake so consecutive words stream without a bubble.
    assign w_pop   = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_LO) & byte_ready));

    // A pop in the same cycle frees the slot the capture needs.
    assign w_push  = w_cap & (~w_full | w_pop);
    assign w_drop  = w_cap & ~w_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status_d <= 1'b0;
        end else begin
            r_status_d <= status_in;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= result_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            // Clear first, then a coincident drop counts as the first new one.
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (clear_stats) begin
                    r_drop_count <= CNT_W'(1);
                end else if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
            end else if (clear_stats) begin
                r_overflow   <= 1'b0;
                r_drop_count <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_byte_out   <= '0;
            r_lo_byte    <= '0;
            r_byte_valid <= 1'b0;
            r_byte_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_byte_out   <= w_head[15:8];
                        r_lo_byte    <= w_head[7:0];
                        r_byte_valid <= 1'b1;
                        r_byte_last  <= 1'b0;
                        r_state      <= S_HI;
                    end
                end
                S_HI: begin
                    if (byte_ready) begin
                        r_byte_out  <= r_lo_byte;
                        r_byte_last <= 1'b1;
                        r_state     <= S_LO;
                    end
                end
                S_LO: begin
                    if (byte_ready) begin
                        if (w_pop) begin
                            r_byte_out   <= w_head[15:8];
                            r_lo_byte    <= w_head[7:0];
                            r_byte_last  <= 1'b0;
                            r_state      <= S_HI;
                        end else begin
                            r_byte_out   <= '0;
                            r_byte_valid <= 1'b0;
                            r_byte_last  <= 1'b0;
                            r_state      <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_byte_out   <= '0;
                    r_byte_valid <= 1'b0;
                    r_byte_last  <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;
    assign byte_last  = r_byte_last;
    assign fifo_level = w_level;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_result_byte_packer.sv
// tb/tb_result_byte_packer.sv - randomized self-checking bench for result_byte_packer

module tb_result_byte_packer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [15:0]            result_in;
    logic                   status_in;
    logic                   enable;
    logic                   clear_stats;
    logic [7:0]             byte_out;
    logic                   byte_valid;
    logic                   byte_ready;
    logic                   byte_last;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   overflow;
    logic [CNT_W-1:0]       drop_count;

    always #5 clk = ~clk;

    result_byte_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .result_in   (result_in),
        .status_in   (status_in),
        .enable      (enable),
        .clear_stats (clear_stats),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .byte_last   (byte_last),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    int n_checks   = 0;
    int n_fail     = 0;
    int words_seen = 0;

    // Reference: queue of stored words plus the word being emitted and how
    // many of its bytes remain to be accepted.
    logic [15:0] m_q[$];
    logic [15:0] m_cur;
    int          m_left;
    logic        m_sd;
    logic        m_ov;
    int          m_dc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cur  = '0;
        m_left = 0;
        m_sd   = 1'b0;
        m_ov   = 1'b0;
        m_dc   = 0;
    endtask

    task automatic set_in(input logic r, input logic st, input logic en,
                          input logic rdy, input logic clr);
        rst         = r;
        status_in   = st;
        enable      = en;
        byte_ready  = rdy;
        clear_stats = clr;
    endtask

    // Check outputs against the reference, advance one clock, update the reference.
    task automatic do_cycle();
        bit hs, pop, cap, push, drop;
        logic [15:0] word_in;
        check("valid", {31'd0, byte_valid}, {31'd0, m_left > 0});
        if (m_left > 0) begin
            check("byte", {24'd0, byte_out}, {24'd0, (m_left == 2) ? m_cur[15:8] : m_cur[7:0]});
            check("last", {31'd0, byte_last}, {31'd0, m_left == 1});
        end
        check("level", {29'd0, fifo_level}, m_q.size());
        check("overflow", {31'd0, overflow}, {31'd0, m_ov});
        check("drop_count", {24'd0, drop_count}, m_dc);
        if (byte_valid && byte_ready && byte_last) words_seen++;

        hs      = (m_left > 0) && byte_ready;
        pop     = (m_q.size() > 0) && ((m_left == 0) || (m_left == 1 && hs));
        cap     = status_in && !m_sd && enable;
        push    = cap && ((m_q.size() < DEPTH) || pop);
        drop    = cap && !push;
        word_in = result_in;

        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (pop) begin
                m_cur  = m_q.pop_front();
                m_left = 2;
            end else if (hs) begin
                m_left = m_left - 1;
            end
            if (push) m_q.push_back(word_in);
            if (clear_stats) begin
                m_ov = 1'b0;
                m_dc = 0;
            end
            if (drop) begin
                m_ov = 1'b1;
                m_dc = (m_dc == 255) ? 255 : m_dc + 1;
            end
            m_sd = status_in;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte"},  {24'd0, byte_out}, 0);
        check({tag, "_valid"}, {31'd0, byte_valid}, 0);
        check({tag, "_last"},  {31'd0, byte_last}, 0);
        check({tag, "_level"}, {29'd0, fifo_level}, 0);
        check({tag, "_ov"},    {31'd0, overflow}, 0);
        check({tag, "_dc"},    {24'd0, drop_count}, 0);
    endtask

    initial begin
        int w0;
        logic [15:0] words [3];
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        result_in = '0;
        set_in(1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all_zero("reset");
        do_cycle();

        // Single word, bytes A5 then 5A
        result_in = 16'hA55A;
        w0 = words_seen;
        set_in(0, 1, 1, 1, 0);
        do_cycle();
        set_in(0, 0, 1, 1, 0);
        repeat (6) do_cycle();
        check("single_words", words_seen - w0, 1);

        // Held flag: one capture only
        result_in = 16'hBEEF;
        w0 = words_seen;
        set_in(0, 1, 1, 1, 0);
        repeat (10) do_cycle();
        set_in(0, 0, 1, 1, 0);
        repeat (5) do_cycle();
        check("held_words", words_seen - w0, 1);

        // Edge while disabled, then enable with flag still high: no capture
        w0 = words_seen;
        set_in(0, 1, 0, 1, 0);
        repeat (2) do_cycle();
        set_in(0, 1, 1, 1, 0);
        repeat (4) do_cycle();
        check("disabled_level", {29'd0, fifo_level}, 0);
        check("disabled_valid", {31'd0, byte_valid}, 0);
        check("disabled_words", words_seen - w0, 0);
        set_in(0, 0, 1, 1, 0);
        do_cycle();

        // Overflow: 7 edges with no ready
        for (int i = 0; i < 7; i++) begin
            result_in = 16'h0100 + 16'(i);
            set_in(0, 1, 1, 0, 0);
            do_cycle();
            set_in(0, 0, 1, 0, 0);
            do_cycle();
        end
        check("ovf_level", {29'd0, fifo_level}, 4);
        check("ovf_flag", {31'd0, overflow}, 1);
        check("ovf_dc", {24'd0, drop_count}, 2);

        // Full FIFO, capture coincides with the LO-handshake pop
        set_in(0, 0, 1, 1, 0);
        do_cycle();
        result_in = 16'hC0DE;
        set_in(0, 1, 1, 1, 0);
        do_cycle();
        check("fullpop_level", {29'd0, fifo_level}, 4);
        check("fullpop_dc", {24'd0, drop_count}, 2);

        // Clear coincident with a drop
        set_in(0, 0, 1, 0, 0);
        do_cycle();
        set_in(0, 1, 1, 0, 1);
        do_cycle();
        check("clrdrop_dc", {24'd0, drop_count}, 1);
        check("clrdrop_ov", {31'd0, overflow}, 1);

        // Reset mid-HI discards everything
        set_in(1, 0, 0, 0, 0);
        do_cycle();
        check_all_zero("rst_mid");
        set_in(0, 0, 1, 0, 0);
        repeat (3) do_cycle();

        // Backpressure on three words
        for (int i = 0; i < 3; i++) begin
            result_in = words[i];
            set_in(0, 1, 1, 1'($urandom_range(0, 1)), 0);
            do_cycle();
            set_in(0, 0, 1, 1'($urandom_range(0, 1)), 0);
            do_cycle();
        end
        for (int i = 0; i < 40; i++) begin
            set_in(0, 0, 1, 1'($urandom_range(0, 1)), 0);
            do_cycle();
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            result_in = 16'($urandom);
            set_in($urandom_range(0, 199) == 0,
                   1'($urandom_range(0, 1)),
                   $urandom_range(0, 9) != 0,
                   $urandom_range(0, 9) < 6,
                   $urandom_range(0, 39) == 0);
            do_cycle();
        end
        set_in(0, 0, 1, 1, 0);
        repeat (20) do_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
